// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: memory-op encodings,
// stage FSM states and small op-classification helpers.
package mem_stage_pkg;

  localparam int MEM_OP_WIDTH = 3;

  typedef logic [MEM_OP_WIDTH-1:0] mem_op_t;

  localparam mem_op_t MEM_NONE = 3'd0;
  localparam mem_op_t MEM_LW   = 3'd1;
  localparam mem_op_t MEM_LB   = 3'd2;
  localparam mem_op_t MEM_LBU  = 3'd3;
  localparam mem_op_t MEM_SW   = 3'd4;
  localparam mem_op_t MEM_SB   = 3'd5;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUS  = 1'b1
  } state_e;

  // Unassigned encodings behave exactly like MEM_NONE.
  function automatic mem_op_t mem_op_norm(input mem_op_t op);
    mem_op_t r;
    case (op)
      MEM_LW, MEM_LB, MEM_LBU, MEM_SW, MEM_SB: r = op;
      default:                                 r = MEM_NONE;
    endcase
    return r;
  endfunction

  function automatic logic is_store_op(input mem_op_t op);
    return (op == MEM_SW) || (op == MEM_SB);
  endfunction

  function automatic logic is_word_op(input mem_op_t op);
    return (op == MEM_LW) || (op == MEM_SW);
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed little-endian byte lane and
// sign- or zero-extends it; word loads pass the bus data through.
module mem_stage_load_align
  import mem_stage_pkg::*;
(
  input  logic [31:0] rdata_i,
  input  logic [1:0]  lane_i,
  input  mem_op_t     mem_op_i,
  output logic [31:0] data_o
);

  logic [7:0] byte_s;

  // Byte lane select.
  always_comb begin
    byte_s = rdata_i[7:0];
    case (lane_i)
      2'd0:    byte_s = rdata_i[7:0];
      2'd1:    byte_s = rdata_i[15:8];
      2'd2:    byte_s = rdata_i[23:16];
      2'd3:    byte_s = rdata_i[31:24];
      default: byte_s = rdata_i[7:0];
    endcase
  end

  // Extension according to load flavour.
  always_comb begin
    data_o = rdata_i;
    case (mem_op_i)
      MEM_LW:  data_o = rdata_i;
      MEM_LB:  data_o = {{24{byte_s[7]}}, byte_s};
      MEM_LBU: data_o = {24'd0, byte_s};
      default: data_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: turns the ALU result into a writeback or a bus
// load/store with req/ack handshake, timeout and misalignment detection.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_alu_result,
  input  logic [31:0] in_store_data,
  input  logic [2:0]  in_mem_op,
  input  logic [4:0]  in_wb_reg,
  input  logic        in_wb_en,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        wb_valid,
  output logic [4:0]  wb_reg,
  output logic [31:0] wb_data,
  output logic        addr_error,
  output logic        bus_timeout
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mem_op_t          op_q, op_d;
  logic [1:0]       lane_q, lane_d;
  logic [4:0]       ld_reg_q, ld_reg_d;
  logic             ld_wb_q, ld_wb_d;
  logic             bus_req_q, bus_req_d;
  logic             bus_we_q, bus_we_d;
  logic [31:0]      bus_addr_q, bus_addr_d;
  logic [31:0]      bus_wdata_q, bus_wdata_d;
  logic [3:0]       bus_be_q, bus_be_d;
  logic             wb_valid_q, wb_valid_d;
  logic [4:0]       wb_reg_q, wb_reg_d;
  logic [31:0]      wb_data_q, wb_data_d;
  logic             addr_error_q, addr_error_d;
  logic             bus_timeout_q, bus_timeout_d;

  mem_op_t     op_in_s;
  logic        accept_s;
  logic        wb_fire_s;
  logic [31:0] ld_data_s;

  assign op_in_s   = mem_op_norm(in_mem_op);
  assign in_ready  = (state_q == ST_IDLE);
  assign accept_s  = in_valid && in_ready;
  assign wb_fire_s = in_wb_en && (in_wb_reg != 5'd0);

  mem_stage_load_align u_load_align (
    .rdata_i  (bus_rdata),
    .lane_i   (lane_q),
    .mem_op_i (op_q),
    .data_o   (ld_data_s)
  );

  // Next-state and registered-output logic for the IDLE/BUS controller.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    lane_d        = lane_q;
    ld_reg_d      = ld_reg_q;
    ld_wb_d       = ld_wb_q;
    bus_req_d     = bus_req_q;
    bus_we_d      = bus_we_q;
    bus_addr_d    = bus_addr_q;
    bus_wdata_d   = bus_wdata_q;
    bus_be_d      = bus_be_q;
    wb_valid_d    = 1'b0;
    wb_reg_d      = wb_reg_q;
    wb_data_d     = wb_data_q;
    addr_error_d  = 1'b0;
    bus_timeout_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!accept_s) begin
          state_d = ST_IDLE;
        end else if (op_in_s == MEM_NONE) begin
          wb_valid_d = wb_fire_s;
          if (wb_fire_s) begin
            wb_reg_d  = in_wb_reg;
            wb_data_d = in_alu_result;
          end else begin
            wb_reg_d  = wb_reg_q;
            wb_data_d = wb_data_q;
          end
        end else if (is_word_op(op_in_s) && (in_alu_result[1:0] != 2'b00)) begin
          addr_error_d = 1'b1;
        end else begin
          state_d    = ST_BUS;
          cnt_d      = '0;
          op_d       = op_in_s;
          lane_d     = in_alu_result[1:0];
          ld_reg_d   = in_wb_reg;
          ld_wb_d    = wb_fire_s && !is_store_op(op_in_s);
          bus_req_d  = 1'b1;
          bus_we_d   = is_store_op(op_in_s);
          bus_addr_d = {in_alu_result[31:2], 2'b00};
          case (op_in_s)
            MEM_SW: begin
              bus_wdata_d = in_store_data;
              bus_be_d    = 4'b1111;
            end
            MEM_SB: begin
              bus_wdata_d = {4{in_store_data[7:0]}};
              bus_be_d    = 4'b0001 << in_alu_result[1:0];
            end
            default: begin
              bus_wdata_d = 32'd0;
              bus_be_d    = 4'b1111;
            end
          endcase
        end
      end

      ST_BUS: begin
        // Ack beats the timeout when both land on the last allowed cycle.
        if (bus_ack) begin
          state_d    = ST_IDLE;
          bus_req_d  = 1'b0;
          wb_valid_d = ld_wb_q;
          if (ld_wb_q) begin
            wb_reg_d  = ld_reg_q;
            wb_data_d = ld_data_s;
          end else begin
            wb_reg_d  = wb_reg_q;
            wb_data_d = wb_data_q;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d       = ST_IDLE;
          bus_req_d     = 1'b0;
          bus_timeout_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d   = ST_IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and output registers; async reset abandons any bus transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      op_q          <= MEM_NONE;
      lane_q        <= 2'd0;
      ld_reg_q      <= 5'd0;
      ld_wb_q       <= 1'b0;
      bus_req_q     <= 1'b0;
      bus_we_q      <= 1'b0;
      bus_addr_q    <= 32'd0;
      bus_wdata_q   <= 32'd0;
      bus_be_q      <= 4'd0;
      wb_valid_q    <= 1'b0;
      wb_reg_q      <= 5'd0;
      wb_data_q     <= 32'd0;
      addr_error_q  <= 1'b0;
      bus_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      op_q          <= op_d;
      lane_q        <= lane_d;
      ld_reg_q      <= ld_reg_d;
      ld_wb_q       <= ld_wb_d;
      bus_req_q     <= bus_req_d;
      bus_we_q      <= bus_we_d;
      bus_addr_q    <= bus_addr_d;
      bus_wdata_q   <= bus_wdata_d;
      bus_be_q      <= bus_be_d;
      wb_valid_q    <= wb_valid_d;
      wb_reg_q      <= wb_reg_d;
      wb_data_q     <= wb_data_d;
      addr_error_q  <= addr_error_d;
      bus_timeout_q <= bus_timeout_d;
    end
  end

  assign bus_req     = bus_req_q;
  assign bus_we      = bus_we_q;
  assign bus_addr    = bus_addr_q;
  assign bus_wdata   = bus_wdata_q;
  assign bus_be      = bus_be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_reg      = wb_reg_q;
  assign wb_data     = wb_data_q;
  assign addr_error  = addr_error_q;
  assign bus_timeout = bus_timeout_q;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage with a scoreboard of expected writeback,
// address-error and timeout events.
module tb_mem_stage;
  import mem_stage_pkg::*;

  localparam logic [2:0] K_WB = 3'b100;
  localparam logic [2:0] K_AE = 3'b010;
  localparam logic [2:0] K_TO = 3'b001;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [2:0]  in_mem_op;
  logic [4:0]  in_wb_reg;
  logic        in_wb_en;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_be;
  logic        bus_ack;
  logic [31:0] bus_rdata;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic [31:0] wb_data;
  logic        addr_error;
  logic        bus_timeout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [2:0]  kind;
    logic [4:0]  rg;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];

  mem_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_alu_result (in_alu_result),
    .in_store_data (in_store_data),
    .in_mem_op     (in_mem_op),
    .in_wb_reg     (in_wb_reg),
    .in_wb_en      (in_wb_en),
    .bus_req       (bus_req),
    .bus_we        (bus_we),
    .bus_addr      (bus_addr),
    .bus_wdata     (bus_wdata),
    .bus_be        (bus_be),
    .bus_ack       (bus_ack),
    .bus_rdata     (bus_rdata),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .wb_data       (wb_data),
    .addr_error    (addr_error),
    .bus_timeout   (bus_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [2:0] k, input logic [4:0] r, input logic [31:0] d);
    exp_t e;
    e.kind = k;
    e.rg   = r;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic scoreboard();
    logic [2:0] k;
    exp_t e;
    k = {wb_valid, addr_error, bus_timeout};
    if (k != 3'b000) begin
      chk("evt_exclusive", 32'($countones(k)), 32'd1);
      if (exp_q.size() == 0) begin
        chk("unexpected_evt", {29'd0, k}, 32'd0);
      end else begin
        e = exp_q.pop_front();
        chk("evt_kind", {29'd0, k}, {29'd0, e.kind});
        if (e.kind == K_WB) begin
          chk("wb_reg", {27'd0, wb_reg}, {27'd0, e.rg});
          chk("wb_data", wb_data, e.data);
        end
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    scoreboard();
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd,
                       input logic [4:0] rg, input logic en);
    chk("in_ready_pre", {31'd0, in_ready}, 32'd1);
    in_valid      = 1'b1;
    in_mem_op     = op;
    in_alu_result = addr;
    in_store_data = sd;
    in_wb_reg     = rg;
    in_wb_en      = en;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic do_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] rd,
                         input logic [4:0] rg, input logic [31:0] expd, input int waits);
    push(K_WB, rg, expd);
    issue(op, addr, 32'h0, rg, 1'b1);
    chk("ld_req", {31'd0, bus_req}, 32'd1);
    chk("ld_we", {31'd0, bus_we}, 32'd0);
    chk("ld_addr", bus_addr, {addr[31:2], 2'b00});
    chk("ld_be", {28'd0, bus_be}, 32'hF);
    chk("ld_busy", {31'd0, in_ready}, 32'd0);
    for (int i = 0; i < waits; i++) begin
      tick();
      chk("ld_hold_req", {31'd0, bus_req}, 32'd1);
      chk("ld_hold_addr", bus_addr, {addr[31:2], 2'b00});
      chk("ld_hold_rdy", {31'd0, in_ready}, 32'd0);
    end
    bus_ack   = 1'b1;
    bus_rdata = rd;
    tick();
    bus_ack   = 1'b0;
    bus_rdata = 32'h5A5A_5A5A;
    chk("ld_req_drop", {31'd0, bus_req}, 32'd0);
    chk("ld_rdy_back", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] sd,
                          input logic [3:0] be, input logic [31:0] wd);
    issue(op, addr, sd, 5'd9, 1'b1);
    chk("st_req", {31'd0, bus_req}, 32'd1);
    chk("st_we", {31'd0, bus_we}, 32'd1);
    chk("st_addr", bus_addr, {addr[31:2], 2'b00});
    chk("st_be", {28'd0, bus_be}, {28'd0, be});
    chk("st_wdata", bus_wdata, wd);
    chk("st_busy", {31'd0, in_ready}, 32'd0);
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("st_req_drop", {31'd0, bus_req}, 32'd0);
    chk("st_rdy_back", {31'd0, in_ready}, 32'd1);
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int req_cycles;
    rst_n         = 1'b1;
    in_valid      = 1'b0;
    in_alu_result = 32'd0;
    in_store_data = 32'd0;
    in_mem_op     = MEM_NONE;
    in_wb_reg     = 5'd0;
    in_wb_en      = 1'b0;
    bus_ack       = 1'b0;
    bus_rdata     = 32'd0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_be", {28'd0, bus_be}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Pass-through writebacks, including back-to-back and reg 0.
    push(K_WB, 5'd3, 32'h0000_1234);
    issue(MEM_NONE, 32'h0000_1234, 32'h0, 5'd3, 1'b1);
    issue(MEM_NONE, 32'h0000_1234, 32'h0, 5'd0, 1'b1);
    push(K_WB, 5'd5, 32'hAAAA_0001);
    issue(MEM_NONE, 32'hAAAA_0001, 32'h0, 5'd5, 1'b1);
    push(K_WB, 5'd31, 32'h0000_0055);
    issue(3'd6, 32'h0000_0055, 32'h0, 5'd31, 1'b1);
    issue(MEM_NONE, 32'h0000_0077, 32'h0, 5'd12, 1'b0);

    // Loads across lanes and extensions.
    do_load(MEM_LB, 32'h0000_1003, 32'h80FF_0000, 5'd4, 32'hFFFF_FF80, 1);
    do_load(MEM_LBU, 32'h0000_1003, 32'h80FF_0000, 5'd4, 32'h0000_0080, 1);
    do_load(MEM_LB, 32'h0000_1001, 32'h0000_7F00, 5'd10, 32'h0000_007F, 0);
    do_load(MEM_LW, 32'h0000_2000, 32'hDEAD_BEEF, 5'd7, 32'hDEAD_BEEF, 2);

    // Stores produce no writeback.
    do_store(MEM_SB, 32'h0000_2001, 32'h1234_56AB, 4'b0010, 32'hABAB_ABAB);
    do_store(MEM_SW, 32'h0000_3000, 32'hCAFE_F00D, 4'b1111, 32'hCAFE_F00D);

    // Misaligned word accesses.
    push(K_AE, 5'd0, 32'd0);
    issue(MEM_LW, 32'h0000_0006, 32'h0, 5'd2, 1'b1);
    chk("ae_no_req", {31'd0, bus_req}, 32'd0);
    chk("ae_ready", {31'd0, in_ready}, 32'd1);
    tick();
    chk("ae_no_req2", {31'd0, bus_req}, 32'd0);
    push(K_AE, 5'd0, 32'd0);
    issue(MEM_SW, 32'h0000_3002, 32'h1111_2222, 5'd0, 1'b0);
    chk("ae_sw_no_req", {31'd0, bus_req}, 32'd0);

    // Ack while idle must be ignored.
    bus_ack = 1'b1;
    tick();
    bus_ack = 1'b0;
    chk("idle_ack_req", {31'd0, bus_req}, 32'd0);

    // Timeout after exactly four request cycles.
    push(K_TO, 5'd0, 32'd0);
    issue(MEM_LW, 32'h0000_0040, 32'h0, 5'd6, 1'b1);
    req_cycles = 0;
    for (int i = 0; i < 10; i++) begin
      if (!bus_req) break;
      req_cycles++;
      tick();
    end
    chk("to_req_cycles", 32'(req_cycles), 32'd4);
    chk("to_ready", {31'd0, in_ready}, 32'd1);

    // Ack on the last allowed cycle wins over timeout.
    do_load(MEM_LW, 32'h0000_0044, 32'h0BAD_F00D, 5'd6, 32'h0BAD_F00D, 3);

    // Reset in the middle of a bus transaction.
    issue(MEM_LW, 32'h0000_0080, 32'h0, 5'd8, 1'b1);
    chk("mid_req", {31'd0, bus_req}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", {31'd0, bus_req}, 32'd0);
    chk("arst_addr", bus_addr, 32'd0);
    chk("arst_be", {28'd0, bus_be}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    bus_ack   = 1'b1;
    bus_rdata = 32'h1234_5678;
    tick();
    rst_n = 1'b1;
    tick();
    bus_ack = 1'b0;
    tick();
    chk("post_rst_req", {31'd0, bus_req}, 32'd0);
    push(K_WB, 5'd1, 32'h0000_0099);
    issue(MEM_NONE, 32'h0000_0099, 32'h0, 5'd1, 1'b1);
    tick();

    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
